// File: rtl/arith_op_sequencer.sv
// Operand-entry and launch controller for the float/fixed add/mul units.
// Captures A then B from the switches on button rises, pulses start, and holds the result.
module arith_op_sequencer #(
  parameter int W           = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   sw,
  input  logic [3:0]     btn,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic [3:0]     unit_start,
  input  logic [3:0]     unit_done,
  input  logic [4*W-1:0] unit_res,
  output logic [W-1:0]   leds,
  output logic [W-1:0]   disp_val,
  output logic [1:0]     op_sel,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_B, S_RUN, S_SHOW} state_t;

  state_t          state, state_n;
  logic [W-1:0]    result, result_n;
  logic [W-1:0]    op_a_n, op_b_n;
  logic [1:0]      op_sel_n;
  logic [3:0]      start_n;
  logic            err_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      btn_prev;
  logic [3:0]      rise;
  logic            any_rise;
  logic [1:0]      win_idx;
  logic            sel_done;
  logic [W-1:0]    sel_res;

  assign rise     = btn & ~btn_prev;
  assign any_rise = |rise;
  assign sel_done = unit_done[op_sel];
  assign sel_res  = unit_res[op_sel*W +: W];

  // Simultaneous rises resolve to the lowest button index.
  always_comb begin
    win_idx = 2'd0;
    if (rise[0])      win_idx = 2'd0;
    else if (rise[1]) win_idx = 2'd1;
    else if (rise[2]) win_idx = 2'd2;
    else if (rise[3]) win_idx = 2'd3;
  end

  always_comb begin
    state_n  = state;
    op_a_n   = op_a;
    op_b_n   = op_b;
    result_n = result;
    op_sel_n = op_sel;
    start_n  = 4'b0000;
    err_n    = err;
    cnt_n    = cnt;
    case (state)
      S_IDLE, S_SHOW: begin
        if (any_rise) begin
          op_a_n   = sw;
          op_sel_n = win_idx;
          err_n    = 1'b0;
          state_n  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (rise[op_sel]) begin
          op_b_n  = sw;
          start_n = 4'b0001 << op_sel;
          cnt_n   = '0;
          state_n = S_RUN;
        end else if (any_rise) begin
          op_sel_n = win_idx;
        end
      end
      S_RUN: begin
        // A done arriving on the final count still counts as success.
        if (sel_done) begin
          result_n = sel_res;
          state_n  = S_SHOW;
        end else if (cnt == CNT_LAST) begin
          result_n = '0;
          err_n    = 1'b1;
          state_n  = S_SHOW;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      op_sel     <= 2'd0;
      unit_start <= 4'b0000;
      err        <= 1'b0;
      cnt        <= '0;
      btn_prev   <= 4'b1111;
    end else begin
      state      <= state_n;
      op_a       <= op_a_n;
      op_b       <= op_b_n;
      result     <= result_n;
      op_sel     <= op_sel_n;
      unit_start <= start_n;
      err        <= err_n;
      cnt        <= cnt_n;
      btn_prev   <= btn;
    end
  end

  assign busy     = (state == S_RUN);
  assign leds     = (state == S_IDLE || state == S_WAIT_B) ? sw : result;
  assign disp_val = (state == S_IDLE)   ? sw   :
                    (state == S_WAIT_B) ? op_a : result;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Directed bench for arith_op_sequencer: operand capture, launch, done/timeout, reset.
module tb_arith_op_sequencer;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   sw = '0;
  logic [3:0]     btn = 4'b0000;
  logic [W-1:0]   op_a, op_b, leds, disp_val;
  logic [3:0]     unit_start;
  logic [3:0]     unit_done = 4'b0000;
  logic [4*W-1:0] unit_res = {16'hDEAD, 16'h0046, 16'hBEEF, 16'hCAFE};
  logic [1:0]     op_sel;
  logic           busy, err;

  int checks = 0;
  int errors = 0;

  arith_op_sequencer #(.W(W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .op_a(op_a), .op_b(op_b),
    .unit_start(unit_start), .unit_done(unit_done), .unit_res(unit_res),
    .leds(leds), .disp_val(disp_val), .op_sel(op_sel), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = 4'b0000; unit_done = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic press(input int i);
    btn = 4'b0001 << i;
    tick();
    btn = 4'b0000;
    tick();
  endtask

  task automatic test_reset();
    sw = 16'h1111; btn = 4'b0001; rst = 1'b1;
    tick(); tick();
    checks++; if (op_a !== 16'h0) begin errors++; $display("FAIL rst_op_a: got %h exp 0000", op_a); end
    checks++; if (op_b !== 16'h0) begin errors++; $display("FAIL rst_op_b: got %h exp 0000", op_b); end
    checks++; if ({unit_start, op_sel, busy, err} !== 8'h00) begin errors++; $display("FAIL rst_ctrl: got start=%b sel=%0d busy=%b err=%b exp all 0", unit_start, op_sel, busy, err); end
    checks++; if (disp_val !== 16'h1111) begin errors++; $display("FAIL rst_disp: got %h exp 1111", disp_val); end
    rst = 1'b0;
    tick(); tick();
    checks++; if (op_a !== 16'h0) begin errors++; $display("FAIL held_btn_no_capture: got op_a=%h exp 0000", op_a); end
    btn = 4'b0000; tick();
    sw = 16'h3C00; press(0);
    sw = 16'h0000; #1;
    checks++; if (op_a !== 16'h3C00) begin errors++; $display("FAIL capture_a: got %h exp 3c00", op_a); end
    checks++; if (disp_val !== 16'h3C00) begin errors++; $display("FAIL wait_b_disp: got %h exp 3c00", disp_val); end
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL wait_b_leds: got %h exp 0000", leds); end
  endtask

  task automatic test_fixed_add();
    do_reset();
    sw = 16'h0012; press(2);
    checks++; if (op_sel !== 2'd2) begin errors++; $display("FAIL fia_sel: got %0d exp 2", op_sel); end
    sw = 16'h0034; btn = 4'b0100; tick(); btn = 4'b0000;
    checks++; if (unit_start !== 4'b0100) begin errors++; $display("FAIL fia_start: got %b exp 0100", unit_start); end
    checks++; if (op_b !== 16'h0034 || busy !== 1'b1) begin errors++; $display("FAIL fia_run: got op_b=%h busy=%b exp 0034 1", op_b, busy); end
    unit_done = 4'b1011; tick();
    checks++; if (unit_start !== 4'b0000) begin errors++; $display("FAIL fia_start_1cyc: got %b exp 0000", unit_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL other_done_ignored: got busy=%b exp 1", busy); end
    unit_done = 4'b0000; tick();
    unit_done = 4'b0100; tick(); unit_done = 4'b0000;
    checks++; if (leds !== 16'h0046 || disp_val !== 16'h0046) begin errors++; $display("FAIL fia_result: got leds=%h disp=%h exp 0046", leds, disp_val); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL fia_show: got busy=%b err=%b exp 0 0", busy, err); end
  endtask

  task automatic test_reselect();
    do_reset();
    sw = 16'h1234; press(0);
    sw = 16'h5678; press(3);
    checks++; if (op_sel !== 2'd3 || op_a !== 16'h1234) begin errors++; $display("FAIL reselect: got sel=%0d op_a=%h exp 3 1234", op_sel, op_a); end
    checks++; if (busy !== 1'b0 || unit_start !== 4'b0000) begin errors++; $display("FAIL reselect_no_launch: got busy=%b start=%b exp 0 0000", busy, unit_start); end
    sw = 16'h9ABC; btn = 4'b1000; tick(); btn = 4'b0000;
    checks++; if (unit_start !== 4'b1000 || op_b !== 16'h9ABC) begin errors++; $display("FAIL fim_start: got start=%b op_b=%h exp 1000 9abc", unit_start, op_b); end
    unit_done = 4'b1000; tick(); unit_done = 4'b0000;
    checks++; if (leds !== 16'hDEAD) begin errors++; $display("FAIL fim_result: got %h exp dead", leds); end
  endtask

  task automatic test_timeout();
    do_reset();
    sw = 16'h0001; press(1);
    btn = 4'b0010; tick(); btn = 4'b0000;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_early: got busy=%b exp 1 after 15 run cycles", busy); end
    tick();
    checks++; if (busy !== 1'b0 || err !== 1'b1 || leds !== 16'h0) begin errors++; $display("FAIL timeout: got busy=%b err=%b leds=%h exp 0 1 0000", busy, err, leds); end
    sw = 16'h4444; press(0);
    checks++; if (err !== 1'b0 || op_a !== 16'h4444 || op_sel !== 2'd0) begin errors++; $display("FAIL timeout_clear: got err=%b op_a=%h sel=%0d exp 0 4444 0", err, op_a, op_sel); end
    btn = 4'b0001; tick(); btn = 4'b0000;
    for (int i = 0; i < 15; i++) tick();
    unit_done = 4'b0001; tick(); unit_done = 4'b0000;
    checks++; if (err !== 1'b0 || leds !== 16'hCAFE || busy !== 1'b0) begin errors++; $display("FAIL done_wins: got err=%b leds=%h busy=%b exp 0 cafe 0", err, leds, busy); end
  endtask

  task automatic test_priority_and_run_lock();
    do_reset();
    sw = 16'h0777; btn = 4'b0110; tick(); btn = 4'b0000; tick();
    checks++; if (op_sel !== 2'd1 || op_a !== 16'h0777) begin errors++; $display("FAIL priority: got sel=%0d op_a=%h exp 1 0777", op_sel, op_a); end
    sw = 16'h0888; btn = 4'b0010; tick(); btn = 4'b0000;
    checks++; if (unit_start !== 4'b0010) begin errors++; $display("FAIL flm_start: got %b exp 0010", unit_start); end
    sw = 16'h0999; press(0); press(2);
    checks++; if (op_sel !== 2'd1 || busy !== 1'b1 || op_a !== 16'h0777 || op_b !== 16'h0888) begin errors++; $display("FAIL run_lock: got sel=%0d busy=%b a=%h b=%h exp 1 1 0777 0888", op_sel, busy, op_a, op_b); end
    unit_done = 4'b0010; tick(); unit_done = 4'b0000;
    checks++; if (leds !== 16'hBEEF) begin errors++; $display("FAIL flm_result: got %h exp beef", leds); end
  endtask

  task automatic test_reset_in_run();
    do_reset();
    sw = 16'h00AA; press(0);
    btn = 4'b0001; tick(); btn = 4'b0000;
    rst = 1'b1; #1;
    checks++; if (unit_start !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_run: got start=%b busy=%b exp 0000 0", unit_start, busy); end
    tick(); rst = 1'b0; tick();
    unit_done = 4'b0001; tick(); unit_done = 4'b0000; tick();
    checks++; if (busy !== 1'b0 || op_a !== 16'h0 || op_b !== 16'h0 || err !== 1'b0 || op_sel !== 2'd0) begin errors++; $display("FAIL rst_idle: got busy=%b a=%h b=%h err=%b sel=%0d exp reset values", busy, op_a, op_b, err, op_sel); end
    checks++; if (leds !== 16'h00AA || disp_val !== 16'h00AA) begin errors++; $display("FAIL rst_idle_disp: got leds=%h disp=%h exp 00aa", leds, disp_val); end
  endtask

  initial begin
    test_reset();
    test_fixed_add();
    test_reselect();
    test_timeout();
    test_priority_and_run_lock();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
